pixel_stride_writer: RTL

Upstream stage of the line-buffer BRAM. Accepts a raster pixel stream on a valid/ready handshake and turns it into BRAM write strobes, using the stride-8 transposed address order (0, 8, …, 2040, 1, 9, …, 2047). It ping-pongs between two 2048-entry banks, raises a full flag per completed block and holds off the source until the downstream reader releases a bank. It also keeps the 5-bit block count.

---
 rtl/pixel_stride_writer_pkg.sv | 24 ++
 rtl/pixel_stride_writer_if.sv | 34 +++
 rtl/pixel_stride_writer_bank_tracker.sv | 76 +++++++
 rtl/pixel_stride_writer.sv | 115 +++++++++++
 4 files changed

// File: rtl/pixel_stride_writer_pkg.sv
// pixel_stride_writer_pkg
// Shared definitions for the line-buffer writer and the reader-side address
// generator: block geometry, counter width, bank state encoding and the
// stride-8 transposed address swizzle.
package pixel_stride_writer_pkg;

    localparam int BLK_PIXELS  = 2048;
    localparam int STRIDE_LOG2 = 3;
    localparam int COUNT_W     = 5;
    localparam int BLK_ADDR_W  = $clog2(BLK_PIXELS);

    typedef enum logic {
        FREE = 1'b0,
        FULL = 1'b1
    } bank_state_e;

    // Raster index -> transposed address. The low index bits become the
    // high address bits, so consecutive pixels land STRIDE apart and the
    // top index bits select the column offset (0, 8, ..., 2040, 1, 9, ...).
    function automatic logic [BLK_ADDR_W-1:0] swizzle_addr(input logic [BLK_ADDR_W-1:0] idx);
        return {idx[BLK_ADDR_W-STRIDE_LOG2-1:0], idx[BLK_ADDR_W-1:BLK_ADDR_W-STRIDE_LOG2]};
    endfunction

endpackage

// File: rtl/pixel_stride_writer_if.sv
// pixel_stride_writer_if
// Bundles the source pixel handshake, the BRAM write port and the
// bank hand-off to the reader.
//   slave  : the writer block (consumes s_*, rd_release; drives the rest)
//   master : the environment (source, BRAM and reader side)
interface pixel_stride_writer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11
);
    import pixel_stride_writer_pkg::*;

    logic                s_valid;
    logic [DATA_W-1:0]   s_data;
    logic                s_ready;
    logic                wr_en;
    logic [ADDR_W:0]     wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                blk_done;
    logic                rd_valid;
    logic                rd_bank;
    logic                rd_release;
    logic [COUNT_W-1:0]  count;

    modport slave (
        input  s_valid, s_data, rd_release,
        output s_ready, wr_en, wr_addr, wr_data, blk_done, rd_valid, rd_bank, count
    );

    modport master (
        output s_valid, s_data, rd_release,
        input  s_ready, wr_en, wr_addr, wr_data, blk_done, rd_valid, rd_bank, count
    );

endinterface

// File: rtl/pixel_stride_writer_bank_tracker.sv
// pixel_stride_writer_bank_tracker
// Ping-pong bank ownership between writer and reader.
//   clk, rst    : clock, asynchronous active-high reset
//   blk_last    : writer is accepting the final pixel of a block this cycle
//   blk_bank    : bank that block was written into
//   rd_release  : reader is done with rd_bank_o
//   full_o      : per-bank FULL flag (block committed, owned by reader)
//   pend_o      : per-bank "final write still in flight" flag
//   rd_bank_o   : oldest full bank, next one the reader consumes
module pixel_stride_writer_bank_tracker
    import pixel_stride_writer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       blk_last,
    input  logic       blk_bank,
    input  logic       rd_release,
    output logic [1:0] full_o,
    output logic [1:0] pend_o,
    output logic       rd_bank_o
);

    logic [1:0] full_w;
    logic       rd_bank_q, rd_bank_d;
    logic       release_hit;

    // Release looks at the pre-edge flag, so a release that coincides with
    // the pend->full promotion of the same bank is dropped.
    assign release_hit = rd_release && full_w[rd_bank_q];

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        bank_state_e full_q, full_d;
        logic        pend_q, pend_d;

        always_comb begin
            // pend only lives for the cycle the final write sits on the port
            pend_d = pend_q ? 1'b0 : (blk_last && (blk_bank == 1'(gi)));
            full_d = full_q;
            if (pend_q) begin
                full_d = FULL;
            end
            if (release_hit && (rd_bank_q == 1'(gi))) begin
                full_d = FREE;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                full_q <= FREE;
                pend_q <= 1'b0;
            end else begin
                full_q <= full_d;
                pend_q <= pend_d;
            end
        end

        assign full_w[gi] = (full_q == FULL);
        assign pend_o[gi] = pend_q;
    end

    always_comb begin
        rd_bank_d = release_hit ? ~rd_bank_q : rd_bank_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_bank_q <= 1'b0;
        end else begin
            rd_bank_q <= rd_bank_d;
        end
    end

    assign full_o    = full_w;
    assign rd_bank_o = rd_bank_q;

endmodule

// File: rtl/pixel_stride_writer.sv
// pixel_stride_writer
// Turns a raster pixel stream into registered BRAM writes in stride-8
// transposed order, ping-ponging between two 2048-entry banks and holding
// the source off while the target bank is still owned by the reader.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of pixel_stride_writer_if
//              s_valid/s_data/s_ready   source handshake
//              wr_en/wr_addr/wr_data    BRAM write port, wr_addr MSB = bank
//              blk_done                 pulse with the final write of a block
//              rd_valid/rd_bank         full bank available to the reader
//              rd_release               reader frees rd_bank
//              count                    completed-block counter (wrapping)
module pixel_stride_writer #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 11,
    parameter int STRIDE_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    pixel_stride_writer_if.slave  bus
);

    localparam int CW = pixel_stride_writer_pkg::COUNT_W;

    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              wr_bank_q, wr_bank_d;
    logic [CW-1:0]     count_q, count_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              blk_done_q, blk_done_d;

    logic [1:0]        full_w, pend_w;
    logic              rd_bank_w;
    logic              s_ready_w, accept, idx_last, blk_last;
    logic [ADDR_W-1:0] swz;

    // Default geometry shares the swizzle with the reader side; any other
    // geometry falls back to the same bit rotation built from the parameters.
    if (ADDR_W == pixel_stride_writer_pkg::BLK_ADDR_W &&
        STRIDE_LOG2 == pixel_stride_writer_pkg::STRIDE_LOG2) begin : g_pkg_swz
        assign swz = pixel_stride_writer_pkg::swizzle_addr(idx_q);
    end else begin : g_param_swz
        assign swz = {idx_q[ADDR_W-STRIDE_LOG2-1:0], idx_q[ADDR_W-1:ADDR_W-STRIDE_LOG2]};
    end

    // Registers only: the target bank must be neither owned by the reader
    // nor still waiting for its final write to commit.
    assign s_ready_w = !rst && !full_w[wr_bank_q] && !pend_w[wr_bank_q];
    assign accept    = bus.s_valid && s_ready_w;
    assign idx_last  = (idx_q == {ADDR_W{1'b1}});
    assign blk_last  = accept && idx_last;

    always_comb begin
        idx_d      = idx_q;
        wr_bank_d  = wr_bank_q;
        count_d    = count_q;
        wr_en_d    = 1'b0;
        blk_done_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (accept) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {wr_bank_q, swz};
            wr_data_d = bus.s_data;
            idx_d     = idx_q + 1'b1;   // wraps to 0 after the last pixel
            if (idx_last) begin
                blk_done_d = 1'b1;
                wr_bank_d  = ~wr_bank_q;
                count_d    = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q      <= '0;
            wr_bank_q  <= 1'b0;
            count_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            blk_done_q <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            wr_bank_q  <= wr_bank_d;
            count_q    <= count_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            blk_done_q <= blk_done_d;
        end
    end

    pixel_stride_writer_bank_tracker u_bank (
        .clk        (clk),
        .rst        (rst),
        .blk_last   (blk_last),
        .blk_bank   (wr_bank_q),
        .rd_release (bus.rd_release),
        .full_o     (full_w),
        .pend_o     (pend_w),
        .rd_bank_o  (rd_bank_w)
    );

    assign bus.s_ready  = s_ready_w;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.blk_done = blk_done_q;
    assign bus.rd_valid = full_w[rd_bank_w];
    assign bus.rd_bank  = rd_bank_w;
    assign bus.count    = count_q;

endmodule
